// File: rtl/pipe_out_gen.sv
// Host pipe-out source: counter/LFSR/walker/fixed data generators
// behind a virtual FIFO whose fill rate is set by a rotating mask.
module pipe_out_gen #(
  parameter int READY_THRESH = 1024,
  parameter int LEVEL_MAX    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_out_read,
  output logic [31:0] pipe_out_data,
  output logic        pipe_out_ready,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic [31:0] fixed_pattern,
  input  logic [2:0]  pattern,
  output logic [31:0] words_sent,
  output logic [31:0] underrun_count
);

  localparam logic [16:0] LMAX = 17'(LEVEL_MAX);
  localparam logic [16:0] RTHR = 17'(READY_THRESH);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lf_q, lf_d;
  logic [31:0] wk_q, wk_d;
  logic        ph_q, ph_d;
  logic [16:0] lvl_q, lvl_d;
  logic [31:0] thr_q, thr_d;
  logic        rdy_q, rdy_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] und_q, und_d;

  always_comb begin
    cnt_d  = cnt_q;
    lf_d   = lf_q;
    wk_d   = wk_q;
    ph_d   = ph_q;
    sent_d = sent_q;
    und_d  = und_q;
    if (pipe_out_read) begin
      cnt_d  = cnt_q + 32'd1;
      lf_d   = {lf_q[30:0],
                lf_q[31] ^ lf_q[21] ^ lf_q[1] ^ lf_q[0]};
      wk_d   = {wk_q[30:0], wk_q[31]};
      ph_d   = ~ph_q;
      sent_d = sent_q + 32'd1;
      if (lvl_q == '0) und_d = und_q + 32'd1;
    end
  end

  // Read and fill in the same cycle cancel out.
  always_comb begin
    lvl_d = lvl_q;
    unique case ({pipe_out_read, thr_q[0]})
      2'b01: if (lvl_q < LMAX) lvl_d = lvl_q + 17'd1;
      2'b10: if (lvl_q != '0) lvl_d = lvl_q - 17'd1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_comb begin
    thr_d = throttle_set ? throttle_val
                         : {thr_q[0], thr_q[31:1]};
    rdy_d = (lvl_q >= RTHR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 32'd1;
      lf_q   <= 32'd1;
      wk_q   <= 32'd1;
      ph_q   <= 1'b0;
      lvl_q  <= '0;
      thr_q  <= throttle_val;
      rdy_q  <= 1'b0;
      sent_q <= '0;
      und_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lf_q   <= lf_d;
      wk_q   <= wk_d;
      ph_q   <= ph_d;
      lvl_q  <= lvl_d;
      thr_q  <= thr_d;
      rdy_q  <= rdy_d;
      sent_q <= sent_d;
      und_q  <= und_d;
    end
  end

  always_comb begin
    unique case (pattern)
      3'd0:    pipe_out_data = cnt_q;
      3'd1:    pipe_out_data = fixed_pattern;
      3'd2:    pipe_out_data = lf_q;
      3'd3:    pipe_out_data = wk_q;
      3'd4:    pipe_out_data = ph_q ? ~fixed_pattern
                                    : fixed_pattern;
      default: pipe_out_data = '0;
    endcase
  end

  assign pipe_out_ready = rdy_q;
  assign words_sent     = sent_q;
  assign underrun_count = und_q;

endmodule

// File: tb/tb_pipe_out_gen.sv
// Bench for pipe_out_gen: vector table, corner sequences and
// randomized traffic against a reads-since-reset reference model.
module tb_pipe_out_gen;

  localparam int THRESH = 1024;
  localparam int LMAX   = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_out_read;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic [31:0] fixed_pattern;
  logic [2:0]  pattern;
  logic [31:0] pipe_out_data;
  logic        pipe_out_ready;
  logic [31:0] words_sent;
  logic [31:0] underrun_count;

  logic [31:0] sat_data;
  logic        sat_rdy;
  logic [31:0] sat_sent;
  logic [31:0] sat_und;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_out_gen u_dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_out_read (pipe_out_read),
    .pipe_out_data (pipe_out_data),
    .pipe_out_ready(pipe_out_ready),
    .throttle_set  (throttle_set),
    .throttle_val  (throttle_val),
    .fixed_pattern (fixed_pattern),
    .pattern       (pattern),
    .words_sent    (words_sent),
    .underrun_count(underrun_count)
  );

  // Small ceiling/threshold copy so saturation is reachable quickly.
  pipe_out_gen #(.READY_THRESH(8), .LEVEL_MAX(40)) u_sat (
    .clk           (clk),
    .reset         (reset),
    .pipe_out_read (pipe_out_read),
    .pipe_out_data (sat_data),
    .pipe_out_ready(sat_rdy),
    .throttle_set  (throttle_set),
    .throttle_val  (throttle_val),
    .fixed_pattern (fixed_pattern),
    .pattern       (pattern),
    .words_sent    (sat_sent),
    .underrun_count(sat_und)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] tv);
    reset = 1'b1;
    throttle_val = tv;
    pipe_out_read = 1'b0;
    throttle_set = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Reference model: everything derived from reads since reset.
  int unsigned m_reads;
  logic [31:0] m_lf;
  int          m_lvl;
  bit          m_rdy;
  logic [31:0] m_und;
  logic [31:0] m_tval;
  int          m_tidx;

  task automatic model_reset(input logic [31:0] tv);
    m_reads = 0;
    m_lf = 32'd1;
    m_lvl = 0;
    m_rdy = 1'b0;
    m_und = '0;
    m_tval = tv;
    m_tidx = 0;
  endtask

  function automatic logic [31:0] model_data(
      input logic [2:0] pat, input logic [31:0] fix);
    logic [31:0] one;
    one = 32'd1;
    case (pat)
      3'd0: return 32'(m_reads + 1);
      3'd1: return fix;
      3'd2: return m_lf;
      3'd3: return one << (m_reads % 32);
      3'd4: return (m_reads % 2 == 1) ? ~fix : fix;
      default: return '0;
    endcase
  endfunction

  task automatic model_step(input bit rd, input bit ts,
                            input logic [31:0] tv);
    bit fill;
    fill = m_tval[m_tidx];
    m_rdy = (m_lvl >= THRESH);
    if (rd && m_lvl == 0) m_und++;
    if (rd && !fill && m_lvl > 0) m_lvl--;
    if (!rd && fill && m_lvl < LMAX) m_lvl++;
    if (ts) begin
      m_tval = tv;
      m_tidx = 0;
    end else begin
      m_tidx = (m_tidx + 1) % 32;
    end
    if (rd) begin
      m_reads++;
      m_lf = {m_lf[30:0],
              m_lf[31] ^ m_lf[21] ^ m_lf[1] ^ m_lf[0]};
    end
  endtask

  typedef struct {
    logic [2:0]       pat;
    logic [31:0]      fix;
    int               n;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vt [3];

  initial begin
    logic [31:0] one;
    logic [31:0] exp_w;
    one = 32'd1;
    reset = 1'b1;
    pipe_out_read = 1'b0;
    throttle_set = 1'b0;
    throttle_val = '0;
    fixed_pattern = '0;
    pattern = 3'd0;

    vt[0].pat = 3'd0; vt[0].fix = '0; vt[0].n = 4;
    vt[0].exp = {32'h4, 32'h3, 32'h2, 32'h1};
    vt[1].pat = 3'd2; vt[1].fix = '0; vt[1].n = 4;
    vt[1].exp = {32'hD, 32'h6, 32'h3, 32'h1};
    vt[2].pat = 3'd4; vt[2].fix = 32'hA5A50F0F; vt[2].n = 3;
    vt[2].exp = {32'h0, 32'hA5A50F0F, 32'h5A5AF0F0,
                 32'hA5A50F0F};

    tick();
    do_reset(32'h0);
    chk("rst_data", pipe_out_data, 32'h1);
    chk("rst_ready", {31'd0, pipe_out_ready}, 32'h0);
    chk("rst_sent", words_sent, 32'h0);
    chk("rst_und", underrun_count, 32'h0);

    // Vector table: data presented before each read edge.
    for (int v = 0; v < 3; v++) begin
      pattern = vt[v].pat;
      fixed_pattern = vt[v].fix;
      do_reset(32'h0);
      pipe_out_read = 1'b1;
      for (int i = 0; i < vt[v].n; i++) begin
        chk($sformatf("vec%0d_d%0d", v, i),
            pipe_out_data, vt[v].exp[i]);
        tick();
      end
      pipe_out_read = 1'b0;
      chk($sformatf("vec%0d_sent", v), words_sent,
          32'(vt[v].n));
    end

    // Fill to threshold: ready lags level by one cycle.
    pattern = 3'd0;
    do_reset(32'hFFFFFFFF);
    for (int k = 0; k < 1024; k++) tick();
    chk("rdy_lag0", {31'd0, pipe_out_ready}, 32'h0);
    tick();
    chk("rdy_lag1", {31'd0, pipe_out_ready}, 32'h1);

    // Saturation on the small-ceiling copy (max 40).
    do_reset(32'hFFFFFFFF);
    for (int k = 0; k < 100; k++) tick();
    chk("sat_rdy", {31'd0, sat_rdy}, 32'h1);
    throttle_set = 1'b1;
    throttle_val = 32'h0;
    tick();
    throttle_set = 1'b0;
    pipe_out_read = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("sat_drain40", sat_und, 32'h0);
    tick();
    chk("sat_under", sat_und, 32'h1);
    pipe_out_read = 1'b0;

    // Underruns with empty FIFO, then slow fill once per 32.
    do_reset(32'h0);
    pipe_out_read = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    pipe_out_read = 1'b0;
    chk("und3", underrun_count, 32'h3);
    chk("und3_sent", words_sent, 32'h3);
    chk("und3_rdy", {31'd0, pipe_out_ready}, 32'h0);
    throttle_set = 1'b1;
    throttle_val = 32'h1;
    tick();
    throttle_set = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    pipe_out_read = 1'b1;
    tick();
    chk("slow_hold", underrun_count, 32'h3);
    tick();
    chk("slow_drain", underrun_count, 32'h3);
    tick();
    chk("slow_under", underrun_count, 32'h4);
    pipe_out_read = 1'b0;

    // Walker wrap, then mid-stream reset.
    pattern = 3'd3;
    do_reset(32'h0);
    pipe_out_read = 1'b1;
    for (int i = 0; i < 33; i++) begin
      exp_w = one << (i % 32);
      chk($sformatf("walk%0d", i), pipe_out_data, exp_w);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pipe_out_read = 1'b0;
    chk("mid_rst_data", pipe_out_data, 32'h1);
    chk("mid_rst_sent", words_sent, 32'h0);
    chk("mid_rst_und", underrun_count, 32'h0);

    // Randomized traffic against the reference model.
    do_reset(32'hFFFFFFFF);
    model_reset(32'hFFFFFFFF);
    for (int c = 0; c < 3000; c++) begin
      bit rd;
      bit ts;
      bit rs;
      int pct;
      pct = (c < 1500) ? 10 : 60;
      rd = ($urandom_range(0, 99) < pct);
      ts = ($urandom_range(0, 99) < 2);
      rs = (c >= 1500) && ($urandom_range(0, 299) == 0);
      pipe_out_read = rd;
      throttle_set = ts;
      throttle_val = (c < 1500) ? ($urandom | 32'hFFFF0FFF)
                                : $urandom;
      pattern = 3'($urandom_range(0, 7));
      fixed_pattern = $urandom;
      reset = rs;
      #1;
      chk($sformatf("rnd%0d_data", c), pipe_out_data,
          model_data(pattern, fixed_pattern));
      if (rs) model_reset(throttle_val);
      else model_step(rd, ts, throttle_val);
      tick();
      chk($sformatf("rnd%0d_sent", c), words_sent,
          32'(m_reads));
      chk($sformatf("rnd%0d_und", c), underrun_count, m_und);
      chk($sformatf("rnd%0d_rdy", c),
          {31'd0, pipe_out_ready}, {31'd0, m_rdy});
    end
    reset = 1'b0;
    pipe_out_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_out_gen.md
PIPE_OUT_GEN -- requirements
Module: pipe_out_gen

Interface
REQ-001 SHALL provide parameter READY_THRESH, default 1024, minimum virtual-FIFO level at which pipe_out_ready asserts.
REQ-002 SHALL provide parameter LEVEL_MAX, default 65535, saturation ceiling of the virtual-FIFO level.
REQ-003 SHALL provide port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port pipe_out_read  input  1  host read strobe; one word consumed per cycle high.
REQ-006 SHALL provide port pipe_out_data  output  32  word currently presented to host.
REQ-007 SHALL provide port pipe_out_ready  output  1  registered; block of READY_THRESH words available.
REQ-008 SHALL provide port throttle_set  input  1  load throttle_val into throttle register.
REQ-009 SHALL provide port throttle_val  input  32  circular fill-rate mask.
REQ-010 SHALL provide port fixed_pattern  input  32  constant word for modes 1 and 4.
REQ-011 SHALL provide port pattern  input  3  data mode select.
REQ-012 SHALL provide port words_sent  output  32  count of words read.
REQ-013 SHALL provide port underrun_count  output  32  count of reads while level was 0.

Function
REQ-014 SHALL hold internal state: 32-bit counter cnt, 32-bit LFSR lf, 32-bit walker wk, 1-bit phase ph, 17-bit level, 32-bit throttle.
REQ-015 SHALL advance all generators together on every cycle with pipe_out_read=1, regardless of mode: cnt+1 (wraps 0xFFFFFFFF->0), lf <= {lf[30:0], lf[31]^lf[21]^lf[1]^lf[0]}, wk rotate left by 1, ph toggles.
REQ-016 SHALL drive pipe_out_data combinationally from registered state by pattern: 0 cnt; 1 fixed_pattern; 2 lf; 3 wk; 4 ph?~fixed_pattern:fixed_pattern; 5-7 zero.
REQ-017 SHALL be first-word-fall-through: word on pipe_out_data at an edge with read=1 is consumed; next word visible after that edge; zero extra latency.
REQ-018 SHALL apply a pattern change immediately to the mux without resetting generator state.
REQ-019 SHALL update level by {pipe_out_read, throttle[0]}: 00 hold; 01 +1 (fill) if level<LEVEL_MAX; 10 -1 (drain) if level>0; 11 hold.
REQ-020 SHALL, on read with level=0, leave level at 0, increment underrun_count, still advance generators and words_sent.
REQ-021 SHALL hold level at LEVEL_MAX when fill occurs at LEVEL_MAX (no wrap).
REQ-022 SHALL register pipe_out_ready <= (level >= READY_THRESH) each cycle, using pre-update level (one-cycle lag).
REQ-023 SHALL rotate throttle right each cycle ({t[0], t[31:1]}); throttle_set=1 loads throttle_val instead of rotating that cycle.
REQ-024 SHALL increment words_sent on every read cycle, wrapping at 2^32; underrun_count likewise wraps.

Reset
REQ-025 SHALL on reset=1 set cnt=1, lf=1, wk=1, ph=0, level=0, pipe_out_ready=0, words_sent=0, underrun_count=0, throttle=throttle_val.
REQ-026 SHALL give reset priority over read, throttle_set and fill in the same cycle; mid-stream reset restarts every sequence at its first word.

Verification
REQ-027 Reset, throttle_val=0xFFFFFFFF, no reads -> level reaches 1024 after 1024 cycles; pipe_out_ready rises exactly one cycle later; level saturates at 65535.
REQ-028 pattern=0, 4 consecutive reads -> data 0x00000001,0x00000002,0x00000003,0x00000004; words_sent=4.
REQ-029 pattern=2 from reset, 4 reads -> 0x00000001,0x00000003,0x00000006,0x0000000D.
REQ-030 pattern=4, fixed_pattern=0xA5A50F0F, 3 reads -> 0xA5A50F0F,0x5A5AF0F0,0xA5A50F0F.
REQ-031 throttle_val=0, reset, 3 reads -> underrun_count=3, level=0, pipe_out_ready=0; then throttle_set with 0x00000001 -> level +1 every 32 cycles.
REQ-032 pattern=3, 33 reads then reset mid-stream -> sequence 0x1..0x80000000, 0x1, wrap; after reset data=0x00000001, counters 0.
